v810_rom_reader: RTL and testbench
==================================

# v810_rom_reader

Read-side bridge between the V810 CPU bus and the SDRAM read port holding the BIOS image written by the ROM download path. Turns 32-bit (or 16-bit) CPU instruction/data reads into one or two 16-bit SDRAM read beats and reassembles the word. Holds a one-word sequential prefetch buffer so straight-line fetches complete in one cycle. Sits inside `mycore` between the CPU bus decoder and the `sdram_rd`/`sdram_raddr`/`sdram_dout`/`sdram_rd_rdy` port.

## Interface
- `ROM_BASE`, 25'h0000000: SDRAM byte address of BIOS byte 0.
- `ROM_AW`, 20: BIOS window size is 2^ROM_AW bytes; CPU address bits above this are ignored.
- `sys_clk` in 1: sole clock; SDRAM read port is presented in this domain.
- `reset` in 1: synchronous, active-high.
- `rom_inval` in 1: level; invalidates prefetch buffer (tied to ROM download active).
- `cpu_req` in 1: level; read request, held until `cpu_ack`.
- `cpu_addr` in 32: byte address; bits [1:0] ignored.
- `cpu_be` in 4: byte enables; 4'b0011 / 4'b1100 = halfword read, anything else = full word.
- `cpu_rdata` out 32: read data, valid only while `cpu_ack`=1.
- `cpu_ack` out 1: one-cycle completion pulse.
- `sdram_rd` out 1: one-cycle read-request pulse.
- `sdram_raddr` out 25: byte address, even, held stable from `sdram_rd` until `sdram_rd_rdy`.
- `sdram_dout` in 16: read data, valid when `sdram_rd_rdy`=1.
- `sdram_rd_rdy` in 1: one-cycle pulse, exactly one per `sdram_rd`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Physical address A = ROM_BASE + {cpu_addr[ROM_AW-1:2], 2'b00}. Little-endian: low halfword at A, high at A+2.
- States: IDLE, LO (issue/wait low beat), HI (issue/wait high beat), RESP, PF_LO, PF_HI.
- IDLE + `cpu_req`, full word, buffer valid and tag == cpu_addr[ROM_AW-1:2]: RESP with buffer data, no SDRAM access.
- IDLE + `cpu_req`, full word, miss: LO -> HI -> RESP; on RESP, buffer loaded with word, then PF_LO with tag+1.
- Halfword read: single beat (A for 4'b0011, A+2 for 4'b1100) -> RESP; data in the enabled half of `cpu_rdata`, other half 0; buffer and prefetch untouched.
- PF_LO -> PF_HI -> IDLE; fetches A+4 into buffer, marks valid at completion. Prefetch address wraps modulo 2^ROM_AW within the window.
- `cpu_req` during PF_*: prefetch is never cancelled; request waits, then is evaluated in IDLE (hits if it matched).
- `rom_inval`=1: buffer valid cleared every cycle; prefetch completing while `rom_inval`=1 does not set valid; no new prefetch started.
- `sdram_rd_rdy` seen in IDLE or RESP: ignored.
- Reset: state IDLE, buffer invalid, tag 0; outputs `cpu_ack`=0, `cpu_rdata`=0, `sdram_rd`=0, `sdram_raddr`=ROM_BASE, `busy`=0. Reset mid-beat abandons the beat; its late `sdram_rd_rdy` arrives in IDLE and is ignored.

## Timing
- Hit: `cpu_req` sampled cycle N -> `cpu_ack` cycle N+1.
- Miss: `sdram_rd` at N+1; low beat captured on rd_rdy cycle R1; second `sdram_rd` at R1+1; `cpu_ack` the cycle after second rd_rdy (R2+1). Prefetch `sdram_rd` at R2+2.
- Halfword: `sdram_rd` at N+1, `cpu_ack` at R1+1.
- `cpu_req` must be low in the cycle after `cpu_ack`; a request held high re-evaluates from IDLE (second ack = protocol error, not guarded).
- Buffer hit test uses the registered buffer; a prefetch completing in cycle N serves a hit starting N+1.

## Structure
- Package `v810_rom_pkg`: state enum, halfword BE codes, `ROM_TAG_W` = ROM_AW-2 helper.
- Flat single module; no sub-module is natural at this size.

## Test plan
- Cold read 0x0000_0000, be=4'hF, SDRAM returns 0x1234 then 0xABCD -> rdata 0xABCD1234, SDRAM addrs 0,2; then prefetch addrs 4,6.
- After prefetch completes, read 0x4 -> `cpu_ack` one cycle after `cpu_req`, no `sdram_rd`.
- Read 0x4 issued during PF_LO -> no extra beats, ack after prefetch completes; read 0x100 during PF_HI -> ack after prefetch + 2 new beats at 0x100/0x102.
- Halfword be=4'b1100 at 0x8, SDRAM 0x5A5A -> one beat at addr 0xA, rdata 0x5A5A0000, buffer unchanged.
- Read last word 2^ROM_AW-4 -> prefetch addrs ROM_BASE+0, +2; `rom_inval` pulse -> next read 0x0 misses.
- Reset asserted between `sdram_rd` and `sdram_rd_rdy` -> outputs at reset values, stray rd_rdy ignored, next read behaves as cold miss.

Source files
------------

// File: rtl/v810_rom_pkg.sv
// v810_rom_pkg
//   Shared definitions for the V810 BIOS ROM read bridge:
//   - rom_state_t : read-sequencer states
//   - BE_HALF_LO / BE_HALF_HI : byte-enable codes that select a halfword read
//   - rom_tag_w() : width of a word tag inside a 2^rom_aw byte window
package v810_rom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LO    = 3'd1,
        ST_HI    = 3'd2,
        ST_RESP  = 3'd3,
        ST_PF_LO = 3'd4,
        ST_PF_HI = 3'd5
    } rom_state_t;

    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    // A word tag is the byte offset within the window without its two low bits.
    function automatic int rom_tag_w(input int rom_aw);
        return rom_aw - 2;
    endfunction

endpackage

// File: rtl/v810_rom_reader.sv
// v810_rom_reader
//   Bridges V810 CPU reads of the BIOS window onto a 16-bit SDRAM read port.
//   A full-word read costs two SDRAM beats (low half at A, high half at A+2);
//   a halfword read costs one. After each full-word miss the next sequential
//   word is prefetched into a one-word buffer so straight-line fetches are
//   answered in one cycle without touching SDRAM.
//
// Ports
//   sys_clk, reset        : clock, synchronous active-high reset
//   rom_inval             : level, drops the prefetch buffer and blocks new prefetch
//   cpu_req/addr/be       : CPU read request (held until cpu_ack)
//   cpu_rdata, cpu_ack    : read data, one-cycle completion pulse
//   sdram_rd, sdram_raddr : one-cycle beat request, even byte address held until ready
//   sdram_dout, sdram_rd_rdy : beat data and its one-cycle ready pulse
//   busy                  : sequencer is not idle
module v810_rom_reader
    import v810_rom_pkg::*;
#(
    parameter logic [24:0] ROM_BASE = 25'h0000000,
    parameter int          ROM_AW   = 20
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        rom_inval,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_be,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        sdram_rd,
    output logic [24:0] sdram_raddr,
    input  logic [15:0] sdram_dout,
    input  logic        sdram_rd_rdy,
    output logic        busy
);

    localparam int TAG_W = rom_tag_w(ROM_AW);

    // SDRAM byte address of the word with the given tag.
    function automatic logic [24:0] word_addr(input logic [TAG_W-1:0] tag);
        logic [24:0] off;
        off               = 25'd0;
        off[ROM_AW-1:0]   = {tag, 2'b00};
        return ROM_BASE + off;
    endfunction

    rom_state_t        state_r,     state_s;
    logic [TAG_W-1:0]  req_tag_r,   req_tag_s;
    logic              half_hi_r,   half_hi_s;
    logic              is_half_r,   is_half_s;
    logic              pf_pend_r,   pf_pend_s;
    logic [15:0]       lo_r,        lo_s;
    logic              buf_valid_r, buf_valid_s;
    logic [TAG_W-1:0]  buf_tag_r,   buf_tag_s;
    logic [31:0]       buf_data_r,  buf_data_s;
    logic [24:0]       raddr_r,     raddr_s;
    logic              rd_r,        rd_s;
    logic              ack_r,       ack_s;
    logic [31:0]       rdata_r,     rdata_s;
    logic              busy_r,      busy_s;

    logic [TAG_W-1:0]  cpu_tag_s;
    logic              cpu_half_s;
    logic              hit_s;
    logic              unused_addr_bits_s;

    assign cpu_tag_s  = cpu_addr[ROM_AW-1:2];
    assign cpu_half_s = (cpu_be == BE_HALF_LO) || (cpu_be == BE_HALF_HI);
    // An invalidate in the same cycle as the lookup must already suppress the hit.
    assign hit_s      = buf_valid_r && !rom_inval && (buf_tag_r == cpu_tag_s);
    assign unused_addr_bits_s = ^{cpu_addr[31:ROM_AW], cpu_addr[1:0]};

    // Next-state and datapath decode for the read sequencer.
    always_comb begin
        state_s     = state_r;
        req_tag_s   = req_tag_r;
        half_hi_s   = half_hi_r;
        is_half_s   = is_half_r;
        pf_pend_s   = pf_pend_r;
        lo_s        = lo_r;
        buf_valid_s = buf_valid_r && !rom_inval;
        buf_tag_s   = buf_tag_r;
        buf_data_s  = buf_data_r;
        raddr_s     = raddr_r;
        rd_s        = 1'b0;
        ack_s       = 1'b0;
        rdata_s     = 32'd0;

        case (state_r)
            ST_IDLE: begin
                if (cpu_req) begin
                    req_tag_s = cpu_tag_s;
                    half_hi_s = (cpu_be == BE_HALF_HI);
                    is_half_s = cpu_half_s;
                    if (cpu_half_s) begin
                        pf_pend_s = 1'b0;
                        state_s   = ST_LO;
                        rd_s      = 1'b1;
                        raddr_s   = (cpu_be == BE_HALF_HI) ? word_addr(cpu_tag_s) + 25'd2
                                                           : word_addr(cpu_tag_s);
                    end else if (hit_s) begin
                        pf_pend_s = 1'b0;
                        state_s   = ST_RESP;
                        ack_s     = 1'b1;
                        rdata_s   = buf_data_r;
                    end else begin
                        pf_pend_s = 1'b1;
                        state_s   = ST_LO;
                        rd_s      = 1'b1;
                        raddr_s   = word_addr(cpu_tag_s);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LO: begin
                if (sdram_rd_rdy) begin
                    if (is_half_r) begin
                        state_s = ST_RESP;
                        ack_s   = 1'b1;
                        rdata_s = half_hi_r ? {sdram_dout, 16'h0000} : {16'h0000, sdram_dout};
                    end else begin
                        lo_s    = sdram_dout;
                        state_s = ST_HI;
                        rd_s    = 1'b1;
                        raddr_s = raddr_r + 25'd2;
                    end
                end else begin
                    state_s = ST_LO;
                end
            end
            ST_HI: begin
                if (sdram_rd_rdy) begin
                    state_s     = ST_RESP;
                    ack_s       = 1'b1;
                    rdata_s     = {sdram_dout, lo_r};
                    buf_data_s  = {sdram_dout, lo_r};
                    buf_tag_s   = req_tag_r;
                    buf_valid_s = !rom_inval;
                end else begin
                    state_s = ST_HI;
                end
            end
            ST_RESP: begin
                // Only a full-word miss schedules a prefetch; the tag wraps within the window.
                if (pf_pend_r && !rom_inval) begin
                    state_s   = ST_PF_LO;
                    req_tag_s = req_tag_r + {{(TAG_W-1){1'b0}}, 1'b1};
                    rd_s      = 1'b1;
                    raddr_s   = word_addr(req_tag_r + {{(TAG_W-1){1'b0}}, 1'b1});
                end else begin
                    state_s = ST_IDLE;
                end
                pf_pend_s = 1'b0;
            end
            ST_PF_LO: begin
                if (sdram_rd_rdy) begin
                    lo_s    = sdram_dout;
                    state_s = ST_PF_HI;
                    rd_s    = 1'b1;
                    raddr_s = raddr_r + 25'd2;
                end else begin
                    state_s = ST_PF_LO;
                end
            end
            ST_PF_HI: begin
                if (sdram_rd_rdy) begin
                    state_s     = ST_IDLE;
                    buf_data_s  = {sdram_dout, lo_r};
                    buf_tag_s   = req_tag_r;
                    buf_valid_s = !rom_inval;
                end else begin
                    state_s = ST_PF_HI;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, buffer and registered output update.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            req_tag_r   <= {TAG_W{1'b0}};
            half_hi_r   <= 1'b0;
            is_half_r   <= 1'b0;
            pf_pend_r   <= 1'b0;
            lo_r        <= 16'd0;
            buf_valid_r <= 1'b0;
            buf_tag_r   <= {TAG_W{1'b0}};
            buf_data_r  <= 32'd0;
            raddr_r     <= ROM_BASE;
            rd_r        <= 1'b0;
            ack_r       <= 1'b0;
            rdata_r     <= 32'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            req_tag_r   <= req_tag_s;
            half_hi_r   <= half_hi_s;
            is_half_r   <= is_half_s;
            pf_pend_r   <= pf_pend_s;
            lo_r        <= lo_s;
            buf_valid_r <= buf_valid_s;
            buf_tag_r   <= buf_tag_s;
            buf_data_r  <= buf_data_s;
            raddr_r     <= raddr_s;
            rd_r        <= rd_s;
            ack_r       <= ack_s;
            rdata_r     <= rdata_s;
            busy_r      <= busy_s;
        end
    end

    assign cpu_rdata   = rdata_r;
    assign cpu_ack     = ack_r;
    assign sdram_rd    = rd_r;
    assign sdram_raddr = raddr_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_v810_rom_reader.sv
// tb_v810_rom_reader
//   Self-checking bench for v810_rom_reader. An SDRAM responder returns each
//   beat after a programmable latency from a fixed memory image. Expected
//   results come from a transaction-level model of the one-word buffer
//   (valid + tag), a directed vector table, hand-written overlap/reset
//   sequences and a randomized phase.
module tb_v810_rom_reader;

    localparam logic [24:0] TB_BASE = 25'h0400000;
    localparam int          AW      = 20;

    typedef enum int {K_HIT, K_MISS, K_NOPF, K_HALF} kind_t;
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] rdata;
        kind_t       kind;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, rom_inval, cpu_req;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, sdram_rd, sdram_rd_rdy, busy;
    logic [24:0] sdram_raddr;
    logic [15:0] sdram_dout;

    always #5 clk = ~clk;

    v810_rom_reader #(.ROM_BASE(TB_BASE), .ROM_AW(AW)) dut (
        .sys_clk(clk), .reset(reset), .rom_inval(rom_inval),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .sdram_rd(sdram_rd), .sdram_raddr(sdram_raddr),
        .sdram_dout(sdram_dout), .sdram_rd_rdy(sdram_rd_rdy), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 2;
    int countdown = 0;
    logic [24:0] pend_addr = 25'd0;
    logic [15:0] ov [logic [24:0]];
    logic [24:0] rd_log[$];

    logic        m_valid = 1'b0;
    logic [17:0] m_tag   = 18'd0;

    function automatic logic [15:0] mem_rd(input logic [24:0] a);
        if (ov.exists(a)) return ov[a];
        return a[16:1] ^ 16'hA5C3;
    endfunction

    function automatic logic [24:0] waddr(input logic [17:0] tag);
        return TB_BASE + {5'd0, tag, 2'b00};
    endfunction

    function automatic kind_t predict(input logic [31:0] addr, input logic [3:0] be, input logic inval);
        if (be == 4'b0011 || be == 4'b1100) return K_HALF;
        if (m_valid && !inval && m_tag == addr[19:2]) return K_HIT;
        if (inval) return K_NOPF;
        return K_MISS;
    endfunction

    function automatic logic [31:0] expect_data(input logic [31:0] addr, input logic [3:0] be);
        logic [24:0] a;
        a = waddr(addr[19:2]);
        if (be == 4'b0011) return {16'd0, mem_rd(a)};
        if (be == 4'b1100) return {mem_rd(a + 25'd2), 16'd0};
        return {mem_rd(a + 25'd2), mem_rd(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SDRAM read port: one beat outstanding, answered lat cycles after sdram_rd.
    initial begin
        sdram_rd_rdy = 1'b0;
        sdram_dout   = 16'd0;
        forever begin
            @(negedge clk);
            sdram_rd_rdy = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    sdram_rd_rdy = 1'b1;
                    sdram_dout   = mem_rd(pend_addr);
                    if (busy) check("raddr_stable", {7'd0, sdram_raddr}, {7'd0, pend_addr});
                end
            end
            if (sdram_rd) begin
                pend_addr = sdram_raddr;
                rd_log.push_back(sdram_raddr);
                countdown = lat;
            end
        end
    end

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [31:0] addr, input logic [3:0] be);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        cpu_be   = be;
    endtask

    task automatic wait_ack(output int cyc, output logic [31:0] data);
        logic got;
        got  = 1'b0;
        cyc  = 0;
        data = 32'd0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cpu_ack) begin
                got  = 1'b1;
                data = cpu_rdata;
            end
        end
        cpu_req  = 1'b0;
        cpu_addr = $urandom;
        cpu_be   = 4'($urandom);
        check("ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] exp_data, input kind_t kind);
        logic [24:0] beats[$];
        logic [24:0] a, pf;
        logic [31:0] data;
        int          cyc, exp_cyc, n;
        a  = waddr(addr[19:2]);
        pf = waddr(addr[19:2] + 18'd1);
        beats.delete();
        case (kind)
            K_HALF:  begin beats.push_back((be == 4'b1100) ? a + 25'd2 : a); exp_cyc = 2 + lat; end
            K_MISS:  begin beats = '{a, a + 25'd2, pf, pf + 25'd2}; exp_cyc = 3 + 2 * lat; end
            K_NOPF:  begin beats = '{a, a + 25'd2}; exp_cyc = 3 + 2 * lat; end
            default: exp_cyc = 1;
        endcase
        wait_idle();
        rd_log.delete();
        issue(addr, be);
        wait_ack(cyc, data);
        check("rdata", data, exp_data);
        check("latency", cyc, exp_cyc);
        if (kind == K_MISS) begin
            @(negedge clk);
            check("pf_issue", {sdram_rd, 6'd0, sdram_raddr}, {1'b1, 6'd0, pf});
        end
        wait_idle();
        check("beat_count", rd_log.size(), beats.size());
        n = (rd_log.size() < beats.size()) ? rd_log.size() : beats.size();
        for (int i = 0; i < n; i++) check("beat_addr", {7'd0, rd_log[i]}, {7'd0, beats[i]});
        if (kind == K_MISS) begin
            m_valid = 1'b1;
            m_tag   = addr[19:2] + 18'd1;
        end else if (kind == K_NOPF) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic pulse_inval();
        @(negedge clk);
        rom_inval = 1'b1;
        @(negedge clk);
        rom_inval = 1'b0;
        m_valid   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},   {31'd0, cpu_ack},   32'd0);
        check({tag, "_rdata"}, cpu_rdata,          32'd0);
        check({tag, "_rd"},    {31'd0, sdram_rd},  32'd0);
        check({tag, "_raddr"}, {7'd0, sdram_raddr}, {7'd0, TB_BASE});
        check({tag, "_busy"},  {31'd0, busy},      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[8];
        logic [31:0] data, addr;
        logic [3:0]  be;
        logic [17:0] prev_tag;
        logic        any_s;
        int          cyc, guard;

        ov[TB_BASE + 25'h00000] = 16'h1234;  ov[TB_BASE + 25'h00002] = 16'hABCD;
        ov[TB_BASE + 25'h00004] = 16'h1111;  ov[TB_BASE + 25'h00006] = 16'h2222;
        ov[TB_BASE + 25'h00008] = 16'h3333;  ov[TB_BASE + 25'h0000A] = 16'h5A5A;
        ov[TB_BASE + 25'h00100] = 16'h4444;  ov[TB_BASE + 25'h00102] = 16'h5555;
        ov[TB_BASE + 25'hFFFFC] = 16'h6666;  ov[TB_BASE + 25'hFFFFE] = 16'h7777;

        tbl[0] = '{32'h0000_0000, 4'hF, 32'hABCD_1234, K_MISS};
        tbl[1] = '{32'h0000_0004, 4'hF, 32'h2222_1111, K_HIT};
        tbl[2] = '{32'h0000_0008, 4'hC, 32'h5A5A_0000, K_HALF};
        tbl[3] = '{32'h0000_0004, 4'hF, 32'h2222_1111, K_HIT};
        tbl[4] = '{32'h0000_0008, 4'h3, 32'h0000_3333, K_HALF};
        tbl[5] = '{32'h000F_FFFC, 4'hF, 32'h7777_6666, K_MISS};
        tbl[6] = '{32'h0000_0000, 4'hF, 32'hABCD_1234, K_HIT};
        tbl[7] = '{32'hFFF0_0100, 4'hF, 32'h5555_4444, K_MISS};

        reset = 1'b1; rom_inval = 1'b0; cpu_req = 1'b0; cpu_addr = 32'd0; cpu_be = 4'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        lat = 2;
        for (int i = 0; i < 8; i++) run_txn(tbl[i].addr, tbl[i].be, tbl[i].rdata, tbl[i].kind);

        // Request for the prefetched word arrives while the prefetch is in its low beat.
        wait_idle();
        rd_log.delete();
        issue(32'h200, 4'hF);
        wait_ack(cyc, data);
        check("seqA_first", data, expect_data(32'h200, 4'hF));
        @(negedge clk);
        @(negedge clk);
        check("seqA_in_pf", {31'd0, busy}, 32'd1);
        issue(32'h204, 4'hF);
        wait_ack(cyc, data);
        check("seqA_hit", data, expect_data(32'h204, 4'hF));
        wait_idle();
        check("seqA_beats", rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            check("seqA_b3", {7'd0, rd_log[3]}, {7'd0, TB_BASE + 25'h206});
        end
        m_valid = 1'b1; m_tag = 18'h81;

        // Unrelated request arrives during the high prefetch beat.
        lat = 3;
        rd_log.delete();
        issue(32'h210, 4'hF);
        wait_ack(cyc, data);
        check("seqB_first", data, expect_data(32'h210, 4'hF));
        guard = 0;
        while (rd_log.size() < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("seqB_in_pf_hi", {31'd0, busy}, 32'd1);
        issue(32'h300, 4'hF);
        wait_ack(cyc, data);
        check("seqB_data", data, expect_data(32'h300, 4'hF));
        wait_idle();
        check("seqB_beats", rd_log.size(), 8);
        if (rd_log.size() == 8) begin
            check("seqB_b4", {7'd0, rd_log[4]}, {7'd0, TB_BASE + 25'h300});
            check("seqB_b5", {7'd0, rd_log[5]}, {7'd0, TB_BASE + 25'h302});
            check("seqB_b7", {7'd0, rd_log[7]}, {7'd0, TB_BASE + 25'h306});
        end
        m_valid = 1'b1; m_tag = 18'hC1;

        // Invalidate: pulse drops the buffer; held level suppresses prefetch.
        lat = 1;
        pulse_inval();
        run_txn(32'h304, 4'hF, expect_data(32'h304, 4'hF), K_MISS);
        @(negedge clk);
        rom_inval = 1'b1;
        run_txn(32'h500, 4'hF, expect_data(32'h500, 4'hF), K_NOPF);
        rom_inval = 1'b0;
        run_txn(32'h504, 4'hF, expect_data(32'h504, 4'hF), K_MISS);

        // Reset while a beat is outstanding; its late ready must be ignored.
        lat = 4;
        wait_idle();
        issue(32'h700, 4'hF);
        guard = 0;
        while (!sdram_rd && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("midbeat");
        any_s = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any_s = any_s | cpu_ack | busy | sdram_rd;
        end
        check("stray_ignored", {31'd0, any_s}, 32'd0);
        m_valid = 1'b0;
        run_txn(32'h0, 4'hF, 32'hABCD_1234, K_MISS);

        // Randomized traffic against the buffer model.
        prev_tag = 18'd0;
        for (int n = 0; n < 60; n++) begin
            lat  = $urandom_range(1, 4);
            addr = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2:       addr[19:2] = prev_tag + 18'd1;
                3, 4, 5, 6, 7: addr[19:2] = 18'($urandom_range(0, 7));
                default:       addr[19:2] = 18'h3FFF8 + 18'($urandom_range(0, 7));
            endcase
            case ($urandom_range(0, 4))
                0:       be = 4'b0011;
                1:       be = 4'b1100;
                2:       be = 4'($urandom);
                default: be = 4'hF;
            endcase
            if ($urandom_range(0, 9) == 0) pulse_inval();
            run_txn(addr, be, expect_data(addr, be), predict(addr, be, 1'b0));
            prev_tag = addr[19:2];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
